// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: FSM states, error codes
// and the ASCII constants used by the frame grammar.
package uart_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_ARG = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam logic [1:0] ERR_BAD_CMD  = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

endpackage

// File: rtl/uart_cmd_decoder_ascii_classify.sv
// Combinational byte classifier: letter / hex digit / terminator / space
// flags, the uppercased byte and the hex nibble value of the byte.
module ascii_classify
  import uart_cmd_decoder_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_letter,
  output logic       is_hex,
  output logic       is_term,
  output logic       is_space,
  output logic [7:0] upper,
  output logic [3:0] nibble
);

  logic is_upper;
  logic is_lower;
  logic is_digit;
  logic is_af;

  // Decode the character classes and derive the folded letter and nibble.
  always_comb begin
    is_upper  = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
    is_lower  = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
    is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    // 'A'-'F' and 'a'-'f' share the low nibble 1..6
    is_af     = ((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                ((rx_data >= 8'h61) && (rx_data <= 8'h66));
    is_letter = is_upper || is_lower;
    is_hex    = is_digit || is_af;
    is_term   = (rx_data == CR) || (rx_data == LF);
    is_space  = (rx_data == SP);
    upper     = is_lower ? (rx_data - 8'h20) : rx_data;
    nibble    = 4'd0;
    if (is_digit) begin
      nibble = rx_data[3:0];
    end else if (is_af) begin
      nibble = rx_data[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command frame decoder: letter + up to MAX_DIGITS hex digits + CR/LF.
// Emits one cmd_valid pulse per good frame or one coded err_pulse per bad one.
//
// Handshake: rx_done is a one-clock qualifier for rx_data; a byte is consumed
// in every cycle rx_done=1 (no back-pressure, no busy state). cmd_valid and
// err_pulse are single-cycle, registered, and never high together.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter  int unsigned MAX_DIGITS  = 4,
  parameter  int unsigned TIMEOUT_CYC = 100_000_000,
  localparam int unsigned ARG_W       = 4 * MAX_DIGITS,
  localparam int unsigned NDIG_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic [ARG_W-1:0]  cmd_arg,
  output logic [NDIG_W-1:0] cmd_ndig,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output state_e            dbg_state
);

  logic       is_letter;
  logic       is_hex;
  logic       is_term;
  logic       is_space;
  logic [7:0] upper;
  logic [3:0] nibble;

  ascii_classify u_classify (
    .rx_data   (rx_data),
    .is_letter (is_letter),
    .is_hex    (is_hex),
    .is_term   (is_term),
    .is_space  (is_space),
    .upper     (upper),
    .nibble    (nibble)
  );

  state_e             state_q;
  state_e             state_d;
  logic [7:0]         code_q;
  logic [ARG_W-1:0]   arg_q;
  logic [NDIG_W-1:0]  ndig_q;
  logic [31:0]        tmo_q;
  logic               timeout_hit;
  logic               do_emit;
  logic               do_err;
  logic [1:0]         err_d;
  logic               load_cmd;
  logic               shift_digit;

  assign dbg_state = state_q;

  // Expiry fires on the TIMEOUT_CYC-th idle clock after the last byte; a byte
  // arriving in that same cycle takes priority.
  assign timeout_hit = (TIMEOUT_CYC != 0) && !rx_done && (state_q != ST_IDLE) &&
                       (tmo_q == TIMEOUT_CYC - 1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-byte actions.
  always_comb begin
    state_d     = state_q;
    do_emit     = 1'b0;
    do_err      = 1'b0;
    err_d       = ERR_BAD_CMD;
    load_cmd    = 1'b0;
    shift_digit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          if (is_letter) begin
            load_cmd = 1'b1;
            state_d  = ST_GET_ARG;
          end else if (!(is_term || is_space)) begin
            do_err  = 1'b1;
            err_d   = ERR_BAD_CMD;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_GET_ARG: begin
        if (rx_done) begin
          if (is_hex) begin
            if (32'(ndig_q) < MAX_DIGITS) begin
              shift_digit = 1'b1;
            end else begin
              do_err  = 1'b1;
              err_d   = ERR_OVERFLOW;
              state_d = ST_FLUSH;
            end
          end else if (is_term) begin
            do_emit = 1'b1;
            state_d = ST_IDLE;
          end else begin
            do_err  = 1'b1;
            err_d   = ERR_BAD_CHAR;
            state_d = ST_FLUSH;
          end
        end else if (timeout_hit) begin
          do_err  = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Silent discard: neither bad bytes nor expiry raise errors here.
        if (rx_done) begin
          if (is_term) begin
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame accumulator: command letter, argument shift register, digit count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= 8'h00;
      arg_q  <= '0;
      ndig_q <= '0;
    end else if (load_cmd) begin
      code_q <= upper;
      arg_q  <= '0;
      ndig_q <= '0;
    end else if (shift_digit) begin
      arg_q  <= (arg_q << 4) | ARG_W'(nibble);
      ndig_q <= ndig_q + NDIG_W'(1);
    end
  end

  // Inter-byte timeout counter; runs only while a frame or flush is open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= 32'd0;
    end else if (rx_done || (state_q == ST_IDLE) || timeout_hit) begin
      tmo_q <= 32'd0;
    end else begin
      tmo_q <= tmo_q + 32'd1;
    end
  end

  // Registered outputs: pulses every cycle, data fields held between events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid <= 1'b0;
      err_pulse <= 1'b0;
      cmd_code  <= 8'h00;
      cmd_arg   <= '0;
      cmd_ndig  <= '0;
      err_code  <= 2'd0;
    end else begin
      cmd_valid <= do_emit;
      err_pulse <= do_err;
      if (do_emit) begin
        cmd_code <= code_q;
        cmd_arg  <= arg_q;
        cmd_ndig <= ndig_q;
      end
      if (do_err) begin
        err_code <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed frames plus a randomized byte stream,
// all scored against a frame-level reference model of the command grammar.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int MAXD = 4;
  localparam int TMO  = 50;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic [2:0]  cmd_ndig;
  logic        err_pulse;
  logic [1:0]  err_code;
  state_e      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_decoder #(.MAX_DIGITS(MAXD), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_arg   (cmd_arg),
    .cmd_ndig  (cmd_ndig),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Event word: {stamp[31:0], is_err, err_code[1:0], code[7:0], arg[15:0], ndig[2:0], 2'b0}
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] got;
  logic [63:0] want;
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] mk_cmd(int stamp, logic [7:0] code, logic [15:0] arg, logic [2:0] nd);
    return {stamp[31:0], 1'b0, 2'b00, code, arg, nd, 2'b00};
  endfunction

  function automatic logic [63:0] mk_err(int stamp, logic [1:0] ec);
    return {stamp[31:0], 1'b1, ec, 8'h00, 16'h0000, 3'b000, 2'b00};
  endfunction

  // Monitor: stamp is the number of rising edges so far, i.e. the edge that
  // registered the pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid) obs_q.push_back(mk_cmd(cyc, cmd_code, cmd_arg, cmd_ndig));
      if (err_pulse) obs_q.push_back(mk_err(cyc, err_code));
    end
  end

  // ---------------- reference model ----------------
  // Frame-level view: a frame is either not open, open (letter + digit list),
  // or being discarded until its terminator.
  int          m_open = 0;
  int          m_discard = 0;
  logic [7:0]  m_letter = 8'h00;
  int          m_digits[$];
  int          m_last = 0;

  function automatic int hex_val(logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_expire(int now);
    if ((m_open != 0 || m_discard != 0) && now - m_last >= TMO) begin
      if (m_open != 0) exp_q.push_back(mk_err(m_last + TMO, ERR_TIMEOUT));
      m_open = 0;
      m_discard = 0;
    end
  endtask

  task automatic model_byte(logic [7:0] b, int s);
    bit term;
    bit letter;
    int hv;
    int arg;
    term   = (b == 8'h0D) || (b == 8'h0A);
    letter = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    hv     = hex_val(b);
    // an expiry happens on the TMO-th clock after the previous byte, unless this byte lands there
    model_expire(s - 1);
    m_last = s;
    if (m_discard != 0) begin
      if (term) m_discard = 0;
    end else if (m_open != 0) begin
      if (hv >= 0) begin
        if (m_digits.size() < MAXD) m_digits.push_back(hv);
        else begin exp_q.push_back(mk_err(s, ERR_OVERFLOW)); m_open = 0; m_discard = 1; end
      end else if (term) begin
        arg = 0;
        foreach (m_digits[i]) arg = arg * 16 + m_digits[i];
        exp_q.push_back(mk_cmd(s, m_letter, arg[15:0], 3'(m_digits.size())));
        m_open = 0;
      end else begin
        exp_q.push_back(mk_err(s, ERR_BAD_CHAR)); m_open = 0; m_discard = 1;
      end
    end else begin
      if (letter) begin
        m_letter = (b >= 8'h61) ? b - 8'h20 : b;
        m_digits.delete();
        m_open = 1;
      end else if (!(term || b == 8'h20)) begin
        exp_q.push_back(mk_err(s, ERR_BAD_CMD)); m_discard = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; the byte is sampled by the next rising edge.
  task automatic send(logic [7:0] b, int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, cyc + 1);
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic settle();
    repeat (TMO + 10) @(negedge clk);
    model_expire(cyc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, err_pulse, cmd_code, cmd_arg, cmd_ndig, err_code} !== 31'd0) begin
      errors++;
      $display("FAIL reset outputs got v=%b e=%b code=%h arg=%h nd=%0d ec=%0d want all 0",
               cmd_valid, err_pulse, cmd_code, cmd_arg, cmd_ndig, err_code);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_commands();
    send("S", 10); send("1", 10); send("A", 10); send("F", 10); send(CR, 10);
    repeat (20) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_code, cmd_arg, cmd_ndig} !== {1'b0, 8'h53, 16'h01AF, 3'd3}) begin
      errors++;
      $display("FAIL cmd_hold got v=%b code=%h arg=%h nd=%0d want v=0 code=53 arg=01af nd=3",
               cmd_valid, cmd_code, cmd_arg, cmd_ndig);
    end
    send("r", 3); send(LF, 3);
    send(CR, 3); send(CR, 3); send(SP, 3);
    settle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL commands count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL commands event got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    send("W", 2); send("1", 2); send("2", 2); send("3", 2); send("4", 2); send("5", 2); send(CR, 2);
    repeat (5) @(negedge clk);
    checks++;
    if ({err_code, cmd_code} !== {ERR_OVERFLOW, 8'h52}) begin
      errors++; $display("FAIL err_hold got ec=%0d code=%h want ec=2 code=52", err_code, cmd_code);
    end
    send("C", 2); send(CR, 2);
    send("#", 2); send(CR, 2);
    send("P", 2); send("G", 2); send(CR, 2);
    send("q", 1); send(SP, 1); send("7", 1); send(LF, 1);
    settle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL errors count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL errors event got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    send("A", 2); send("7", 2);
    settle();
    send("9", 2); send(CR, 2);
    // next byte lands exactly on the expiry clock: no timeout
    send("A", 2); send("1", TMO - 1); send(CR, 2);
    // one clock later than that: timeout
    send("D", 2); send("2", TMO);
    send(CR, 2);
    // expiry inside a flush is silent and reopens IDLE
    send("#", 2);
    settle();
    send("B", 2); send(CR, 2);
    settle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL timeout count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL timeout event got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    send("S", 2); send("1", 2);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, err_pulse, cmd_code, cmd_arg, cmd_ndig, err_code} !== 31'd0) begin
      errors++;
      $display("FAIL midframe_reset got v=%b e=%b code=%h arg=%h nd=%0d ec=%0d want all 0",
               cmd_valid, err_pulse, cmd_code, cmd_arg, cmd_ndig, err_code);
    end
    m_open = 0; m_discard = 0; m_digits.delete();
    @(negedge clk);
    rst = 1'b1;
    send("B", 2); send(CR, 2);
    settle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL midframe count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL midframe event got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send("X", 1); send("F", 0); send(LF, 0);
    send("k", 0); send("1", 0); send("2", 0); send(CR, 0);
    send("%", 0); send("a", 0); send(LF, 0); send("E", 0); send(CR, 0);
    settle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL b2b event got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] hexset [16];
    int gap;
    for (int i = 0; i < 10; i++) hexset[i] = 8'(8'h30 + i);
    for (int i = 0; i < 6; i++) begin
      hexset[10 + i] = 8'(8'h41 + i);
    end
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          b = 8'(8'h41 + $urandom_range(0, 25));
          if ($urandom_range(0, 1) == 1) b = b + 8'h20;
        end
        3, 4, 5: begin
          b = hexset[$urandom_range(0, 15)];
          if (b >= 8'h41 && $urandom_range(0, 1) == 1) b = b + 8'h20;
        end
        6, 7: b = ($urandom_range(0, 1) == 1) ? CR : LF;
        8: b = SP;
        default: b = 8'($urandom);
      endcase
      gap = ($urandom_range(0, 11) == 0) ? $urandom_range(TMO - 3, TMO + 2) : $urandom_range(0, 2);
      send(b, gap);
    end
    settle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL random count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL random event got %h want %h", got, want); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_commands();
    test_errors();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
